// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, constants and the buffer entry type for the
//               instruction fetch unit and its 2-entry fetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered fetch: the byte address and the word returned for it.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] word;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : 2-entry FIFO of {pc, word} fetch entries with push, pop and
//               flush. Flush wins over push/pop. The head reads as all-zero
//               when the buffer is empty.
// Ports       : clk, rst_n          - clock, async active-low reset
//               push, push_entry    - write push_entry at the tail
//               pop                 - advance the head (caller guarantees
//                                     count != 0)
//               flush               - discard all entries
//               head                - entry at the head (0 when empty)
//               count               - number of valid entries, 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count_q;

    // When full, wr_ptr == rd_ptr. A simultaneous push/pop overwrites the
    // slot being popped, which is safe because the popped value was already
    // consumed combinationally before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries[0] <= '0;
            entries[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count_q    <= 2'd0;
        end else if (flush) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = (count_q != 2'd0) ? entries[rd_ptr] : '0;

endmodule : fetch_buffer
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch initiator. Owns the PC, addresses a
//               combinational instruction memory and buffers returned words
//               for decode behind a valid/ready handshake. Accepts redirects
//               from execute; a misaligned redirect raises a sticky fault.
// Config      : FETCH_BOUND_CHECK_EN - when defined, fetching at a word index
//               >= IMEM_WORDS is suppressed and raises the sticky fault.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               imem_addr / imem_rdata      - instruction memory port
//               instr_valid/ready, instr,
//               instr_pc                    - decode handshake, head entry
//               redirect_valid, redirect_pc - PC replacement from execute
//               fetch_fault                 - sticky fault, halts fetching
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                IMEM_WORDS = 65536
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               fetch_fault
);

    logic [ADDR_W-1:0] fetch_pc;
    logic              fault;
    logic [1:0]        count;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic              pop;
    logic              has_space;
    logic              want_fetch;
    logic              out_of_range;
    logic              push;
    logic              misaligned;

`ifdef FETCH_BOUND_CHECK_EN
    assign out_of_range = {2'b00, fetch_pc[ADDR_W-1:2]} >= 32'(IMEM_WORDS);
`else
    // Addresses beyond the memory simply alias; the size is not consulted.
    logic unused_imem_words;
    assign unused_imem_words = (IMEM_WORDS == 0);
    assign out_of_range      = 1'b0;
`endif

    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid && instr_ready;
    // A full buffer can still accept a push when the head leaves this cycle.
    assign has_space   = (count != 2'd2) || pop;
    assign want_fetch  = !fault && !redirect_valid && has_space;
    assign push        = want_fetch && !out_of_range;
    assign misaligned  = (redirect_pc[1:0] != 2'b00);

    assign push_entry.pc   = fetch_pc;
    assign push_entry.word = imem_rdata;

    // Redirect outranks everything; the target PC is loaded even when
    // misaligned so it can be inspected after the fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            fault    <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            if (misaligned) begin
                fault <= 1'b1;
            end
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end else if (want_fetch && out_of_range) begin
            fault <= 1'b1;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .count      (count)
    );

    assign imem_addr   = fetch_pc;
    assign instr       = head.word;
    assign instr_pc    = head.pc;
    assign fetch_fault = fault;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A queue-based
//               reference model tracks which fetch addresses decode should
//               see; directed scenarios plus a randomized run compare the
//               DUT outputs against it one cycle at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int          IMEM_WORDS_TB = 4;
    localparam logic [31:0] RESET_PC_TB   = 32'h0000_0000;
`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    // Reference model: next fetch address, addresses held for decode, fault.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic        m_fault;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC_TB),
        .IMEM_WORDS (IMEM_WORDS_TB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   mem_word = 32'h2008_0005;
            32'h4:   mem_word = 32'h2009_0003;
            32'h8:   mem_word = 32'h0109_5020;
            default: mem_word = {a[15:0], a[31:16]} ^ 32'h6B8B_4567;
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    logic [97:0] obs;
    assign obs = {instr_valid, fetch_fault, imem_addr, instr_pc, instr};

    function automatic logic [97:0] model_vec();
        logic v;
        v = (m_q.size() != 0);
        return {v, m_fault, m_pc, v ? m_q[0] : 32'h0, v ? mem_word(m_q[0]) : 32'h0};
    endfunction

    task automatic model_reset();
        m_pc    = RESET_PC_TB;
        m_fault = 1'b0;
        m_q.delete();
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_step();
        bit pop;
        bit space;
        pop   = (m_q.size() != 0) && instr_ready;
        space = (m_q.size() < 2) || pop;
        if (pop) void'(m_q.pop_front());
        if (redirect_valid) begin
            m_q.delete();
            m_pc = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
        end else if (!m_fault && space) begin
            if (BOUND_EN && ((m_pc >> 2) >= IMEM_WORDS_TB)) begin
                m_fault = 1'b1;
            end else begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset across two edges and releases it on a falling edge, so the
    // next rising edge is the first edge out of reset.
    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        checks++; if (imem_addr !== RESET_PC_TB) begin errors++; $display("FAIL reset_imem_addr: got %h want %h", imem_addr, RESET_PC_TB); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
        @(negedge clk);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL pre_first_edge_valid: got %b want 0", instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_edge_valid: got %b want 1", instr_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] words [3];
        words[0] = 32'h2008_0005;
        words[1] = 32'h2009_0003;
        words[2] = 32'h0109_5020;
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (instr_pc !== 32'(4 * k) || instr !== words[k]) begin
                errors++; $display("FAIL stream_%0d: got pc=%h word=%h want pc=%h word=%h", k, instr_pc, instr, 32'(4 * k), words[k]);
            end
            checks++; if (obs !== model_vec()) begin errors++; $display("FAIL stream_model_%0d: got %h want %h", k, obs, model_vec()); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        do_reset();
        instr_ready = 1'b0;
        repeat (5) begin
            tick();
            checks++; if (obs !== model_vec()) begin errors++; $display("FAIL bp_model: got %h want %h", obs, model_vec()); end
        end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr_hold: got %h want 8", imem_addr); end
        checks++; if (instr !== 32'h2008_0005) begin errors++; $display("FAIL bp_head_stable: got %h want 20080005", instr); end
        instr_ready = 1'b1;
        for (int c = 0; c < 10 && got.size() < 3; c++) begin
            if (instr_valid) got.push_back(instr_pc);
            tick();
        end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_drain_count: got %0d want 3", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            checks++; if (got[k] !== 32'(4 * k)) begin errors++; $display("FAIL bp_drain_%0d: got %h want %h", k, got[k], 32'(4 * k)); end
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        instr_ready = 1'b0;
        tick();
        tick();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid: got %b want 0", instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin
            errors++; $display("FAIL redir_target: got valid=%b pc=%h want valid=1 pc=40", instr_valid, instr_pc);
        end
        repeat (3) begin
            tick();
            checks++; if (obs !== model_vec() || instr_pc === 32'h4) begin errors++; $display("FAIL redir_model: got %h want %h", obs, model_vec()); end
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        instr_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fetch_fault !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h42) begin
            errors++; $display("FAIL misalign: got fault=%b valid=%b addr=%h want 1 0 42", fetch_fault, instr_valid, imem_addr);
        end
        repeat (4) tick();
        checks++; if (fetch_fault !== 1'b1 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL misalign_sticky: got fault=%b valid=%b want 1 0", fetch_fault, instr_valid);
        end
        do_reset();
        #1;
        checks++; if (fetch_fault !== 1'b0 || imem_addr !== RESET_PC_TB) begin
            errors++; $display("FAIL misalign_reset: got fault=%b addr=%h want 0 %h", fetch_fault, imem_addr, RESET_PC_TB);
        end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC_TB) begin
            errors++; $display("FAIL misalign_restart: got valid=%b pc=%h want 1 %h", instr_valid, instr_pc, RESET_PC_TB);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got %h want fffffffc", instr_pc); end
        tick();
        checks++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1 || fetch_fault !== 1'b0) begin
            errors++; $display("FAIL wrap_second: got pc=%h valid=%b fault=%b want 0 1 0", instr_pc, instr_valid, fetch_fault);
        end
    endtask

    task automatic test_bound();
        logic [31:0] got[$];
        do_reset();
        instr_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (instr_valid) got.push_back(instr_pc);
            checks++; if (obs !== model_vec()) begin errors++; $display("FAIL bound_model: got %h want %h", obs, model_vec()); end
        end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL bound_count: got %0d want 4", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            checks++; if (got[k] !== 32'(4 * k)) begin errors++; $display("FAIL bound_pc_%0d: got %h want %h", k, got[k], 32'(4 * k)); end
        end
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL bound_fault: got %b want 1", fetch_fault); end
    endtask

    task automatic test_async_reset();
        do_reset();
        instr_ready = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_addr !== RESET_PC_TB) begin
            errors++; $display("FAIL async_reset: got valid=%b instr=%h addr=%h want 0 0 %h", instr_valid, instr, imem_addr, RESET_PC_TB);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (m_fault && $urandom_range(0, 3) == 0) do_reset();
            instr_ready    = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 99) < 7);
            case ($urandom_range(0, 5))
                0:       redirect_pc = $urandom() & 32'hFFFF_FFFC;
                1:       redirect_pc = {$urandom_range(0, 63), 2'b00} | {30'h0, 2'($urandom_range(1, 3))};
                default: redirect_pc = {$urandom_range(0, 7), 2'b00};
            endcase
            tick();
            checks++; if (obs !== model_vec()) begin errors++; $display("FAIL random_%0d: got %h want %h", c, obs, model_vec()); end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_misaligned();
        if (BOUND_EN) test_bound();
        else          test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
